// File: rtl/flash_pattern_gen.sv
// flash_pattern_gen: bursts of NUM_PERIODS fixed-period pulses whose high time cycles through four slot widths.
module flash_pattern_gen #(
    parameter int PERIOD_CYC  = 50000,
    parameter int W0          = 12500,
    parameter int W1          = 7500,
    parameter int W2          = 10000,
    parameter int W3          = 9000,
    parameter int NUM_PERIODS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sta,
    input  logic       loop,
    output logic       f0,
    output logic       busy,
    output logic       done,
    output logic [1:0] idx
);
    localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int PW = $clog2(NUM_PERIODS + 1);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
    state_t state, state_n;
    logic sta_d, start, last_period, f0_n, busy_n, done_n;
    logic [CW-1:0] cnt, cnt_n, w_last;
    logic [PW-1:0] per, per_n, per_inc;
    logic [1:0] idx_n;
    assign start       = sta & ~sta_d;
    assign per_inc     = per + 1'b1;
    assign last_period = per_inc >= PW'(NUM_PERIODS);
    assign w_last      = idx == 2'd0 ? CW'(W0 - 1) :
                         idx == 2'd1 ? CW'(W1 - 1) :
                         idx == 2'd2 ? CW'(W2 - 1) : CW'(W3 - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sta_d <= 1'b0;
            cnt   <= '0;
            per   <= '0;
            idx   <= '0;
            f0    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sta_d <= sta;
            cnt   <= cnt_n;
            per   <= per_n;
            idx   <= idx_n;
            f0    <= f0_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end
    // One counter spans the whole period: HIGH covers 0..W-1, LOW the rest.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        per_n   = per;
        idx_n   = idx;
        case (state)
            IDLE: begin
                state_n = start ? HIGH : IDLE;
                cnt_n   = '0;
                per_n   = '0;
                idx_n   = '0;
            end
            HIGH: begin
                cnt_n   = cnt + 1'b1;
                state_n = cnt == w_last ? LOW : HIGH;
            end
            LOW: begin
                if (cnt == CW'(PERIOD_CYC - 1)) begin
                    cnt_n   = '0;
                    per_n   = last_period ? '0 : per_inc;
                    idx_n   = last_period ? 2'd0 : idx + 1'b1;
                    state_n = last_period ? DONE : HIGH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = loop ? HIGH : IDLE;
                cnt_n   = '0;
                per_n   = '0;
                idx_n   = '0;
            end
        endcase
    end
    // Outputs are registered alongside the state so they line up with it.
    always_comb begin
        f0_n   = state_n == HIGH;
        busy_n = state_n != IDLE;
        done_n = state_n == DONE;
    end
endmodule

// File: tb/tb_flash_pattern_gen.sv
// tb_flash_pattern_gen: two instances (4 and 6 periods) checked every cycle against a burst-position model.
module tb_flash_pattern_gen;
    localparam int P = 10;
    logic clk = 1'b0;
    logic rst = 1'b1, sta = 1'b0, loop = 1'b0;
    logic f0_a, busy_a, done_a, f0_b, busy_b, done_b;
    logic [1:0] idx_a, idx_b;
    logic [4:0] q0[$], q1[$];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    flash_pattern_gen #(.PERIOD_CYC(P), .W0(2), .W1(3), .W2(4), .W3(5), .NUM_PERIODS(4)) dut_a (
        .clk(clk), .rst(rst), .sta(sta), .loop(loop),
        .f0(f0_a), .busy(busy_a), .done(done_a), .idx(idx_a));
    flash_pattern_gen #(.PERIOD_CYC(P), .W0(2), .W1(3), .W2(4), .W3(5), .NUM_PERIODS(6)) dut_b (
        .clk(clk), .rst(rst), .sta(sta), .loop(loop),
        .f0(f0_b), .busy(busy_b), .done(done_b), .idx(idx_b));

    function automatic int w_of(int i);
        return i == 0 ? 2 : i == 1 ? 3 : i == 2 ? 4 : 5;
    endfunction

    // Model: a burst is a position 0..N*P-1 followed by one DONE slot at N*P.
    initial begin
        bit act[2];
        int pos[2];
        bit prev;
        act = '{0, 0};
        pos = '{0, 0};
        prev = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                act = '{0, 0};
                prev = 0;
                q0.push_back(5'b0);
                q1.push_back(5'b0);
            end else begin
                bit ev;
                ev = sta && !prev;
                prev = sta;
                for (int d = 0; d < 2; d++) begin
                    int n, k, o;
                    logic [4:0] e;
                    n = d == 0 ? 4 : 6;
                    if (!act[d]) begin
                        if (ev) begin
                            act[d] = 1;
                            pos[d] = 0;
                        end
                    end else if (pos[d] == n * P) begin
                        if (loop) pos[d] = 0;
                        else act[d] = 0;
                    end else begin
                        pos[d]++;
                    end
                    if (!act[d]) e = 5'b0;
                    else if (pos[d] == n * P) e = 5'b01100;
                    else begin
                        k = pos[d] / P;
                        o = pos[d] % P;
                        e = {o < w_of(k % 4), 1'b1, 1'b0, 2'(k % 4)};
                    end
                    if (d == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                logic [4:0] e;
                e = q0.pop_front();
                tests++;
                if ({f0_a, busy_a, done_a, idx_a} !== e) begin
                    fails++;
                    $display("FAIL dut_a t=%0t {f0,busy,done,idx} got %b exp %b", $time, {f0_a, busy_a, done_a, idx_a}, e);
                end
            end
            if (q1.size() > 0) begin
                logic [4:0] e;
                e = q1.pop_front();
                tests++;
                if ({f0_b, busy_b, done_b, idx_b} !== e) begin
                    fails++;
                    $display("FAIL dut_b t=%0t {f0,busy,done,idx} got %b exp %b", $time, {f0_b, busy_b, done_b, idx_b}, e);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(3);
        rst = 0;
        tick(3);
        sta = 1;
        tick(1);
        sta = 0;
        tick(70);
        sta = 1;
        tick(5);
        for (int i = 0; i < 60; i++) begin
            sta = $urandom_range(0, 3) != 0;
            tick(1);
        end
        sta = 0;
        tick(70);
        loop = 1;
        sta = 1;
        tick(1);
        sta = 0;
        tick(150);
        loop = 0;
        tick(80);
        sta = 1;
        tick(1);
        sta = 0;
        tick(25);
        rst = 1;
        tick(1);
        rst = 0;
        tick(5);
        sta = 1;
        tick(1);
        sta = 0;
        tick(70);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) sta = ~sta;
            if ($urandom_range(0, 49) == 0) loop = ~loop;
            rst = $urandom_range(0, 299) == 0;
            tick(1);
        end
        rst = 0;
        tick(3);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
